mmio_bridge: RTL and testbench
==============================

// Module: mmio_bridge
// PURPOSE
//   Registered bridge between the CPU data-port request channel and the IO MMIO
//   slave (LED/7-seg/button/UART block). Latches one CPU access, checks the IO
//   window and alignment, then sequences req/ready on the MMIO side.
//   Optional read-modify-write support for byte and halfword stores.
//   Returns a one-cycle cpu_ready, with cpu_err flagged on decode error or slave timeout.
// PARAMETERS
//   IO_BASE     `IO_BASE_ADDR  first byte address of the IO window
//   IO_SIZE     32'h100        window size in bytes (power of two)
//   TIMEOUT_CYC 64             max cycles mmio_req waits for mmio_ready (>=2)
// PORTS
//   clk         in   1        system clock
//   rst_n       in   1        asynchronous active-low reset
//   cpu_req     in   1        access request, held until cpu_ready
//   cpu_we      in   1        1 = store, 0 = load
//   cpu_addr    in   ADDR_W   byte address
//   cpu_wdata   in   XLEN     store data, lane-aligned
//   cpu_be      in   4        byte enables (1111/0011/1100/0001..1000)
//   cpu_rdata   out  XLEN     load data, valid while cpu_ready=1
//   cpu_ready   out  1        one-cycle completion pulse
//   cpu_err     out  1        qualifies cpu_ready: access failed
//   mmio_req    out  1        slave request, held until mmio_ready sampled
//   mmio_we     out  1        slave write strobe
//   mmio_addr   out  ADDR_W   word-aligned slave address
//   mmio_wdata  out  XLEN     full-word slave write data
//   mmio_rdata  in   XLEN     slave read data, valid with mmio_ready
//   mmio_ready  in   1        slave completion
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-access drops
//     the transaction and deasserts mmio_req asynchronously; no cpu_ready is issued.
//   - The FSM has four states: IDLE, RD, WR and RESP. All outputs are registered.
//   - IDLE: when cpu_req=1, latch addr/wdata/be/we.
//     - If the address is outside [IO_BASE, IO_BASE+IO_SIZE), go to RESP with err=1.
//     - If the access is misaligned (be pattern not naturally aligned, or be=0), go to RESP with err=1.
//     - A load goes to RD.
//     - A store with be=1111 goes to WR.
//     - A partial store goes to RD (RMW).
//   - RD: mmio_req=1, mmio_we=0 held. When mmio_ready=1 at posedge:
//     - capture mmio_rdata;
//     - for a load, go to RESP with cpu_rdata=capture;
//     - for RMW, merge wdata lanes where be=1 into the capture and go to WR.
//   - WR: mmio_req=1, mmio_we=1, mmio_wdata=merged/full word. When mmio_ready=1,
//     go to RESP with cpu_rdata=0.
//   - RESP: cpu_ready=1 for exactly one cycle, then IDLE. cpu_req is ignored
//     during RESP, so back-to-back accesses need at least one IDLE cycle.
//   - mmio_addr = {latched_addr[ADDR_W-1:2],2'b00}, stable while mmio_req=1.
//   - mmio_req drops in the cycle after mmio_ready is sampled. In RMW there is one
//     cycle with mmio_req=0 between the RD and WR phases.
//   - Timeout: the counter resets on entry to RD/WR and increments each cycle
//     without mmio_ready. Reaching TIMEOUT_CYC-1 goes to RESP with err=1 and
//     cpu_rdata=0. A ready arriving in the same cycle as the timeout wins.
//   - Zero-wait slave: a load takes cpu_req sampled at T, mmio_req high at T+1,
//     and cpu_ready at T+2. A full store has the same latency; an RMW store takes T+4.
//   - On err, no MMIO write is ever issued. On RMW read timeout, WR is skipped.
// CONFIGURATION
//   MMIO_BRIDGE_RMW_EN defined: partial stores are performed as RD->merge->WR,
//     as described above.
//   Not defined: any store with be!=1111 goes to RESP with err=1, no MMIO
//     traffic is issued, and the merge logic is removed.
// TESTING
//   1. Load LED @IO_BASE+`IO_LED_OFFSET after slave holds 0xA5A5 -> cpu_rdata=0000A5A5,
//      err=0, cpu_ready at T+2.
//   2. Store 0x00001234 be=1111 to LED -> one mmio_we=1 beat with wdata 00001234;
//      led_out=1234.
//   3. RMW_EN: LED=0xA5A5, store byte 0x3C be=0001 -> RD beat, then WR wdata
//      0000A53C; readback A53C.
//   4. Address IO_BASE+IO_SIZE, or be=0110 -> cpu_ready with err=1 at T+1,
//      mmio_req never rises.
//   5. Slave model never asserts mmio_ready -> err=1 after TIMEOUT_CYC cycles,
//      mmio_req=0 afterwards.
//   6. Assert rst_n=0 mid-WR -> mmio_req=0 immediately, no cpu_ready; the next access
//      completes normally.

Source files
------------

// File: rtl/mmio_bridge.sv
// ============================================================================
// Module   : mmio_bridge
// Brief    : Registered CPU-to-MMIO bridge with window/alignment decode and a
//            slave timeout. Define MMIO_BRIDGE_RMW_EN to enable partial stores
//            through a read-merge-write sequence.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef IO_BASE_ADDR
`define IO_BASE_ADDR 32'h4000_0000
`endif

module mmio_bridge #(
   parameter int          ADDR_W      = 32,
   parameter int          XLEN        = 32,
   parameter logic [31:0] IO_BASE     = `IO_BASE_ADDR,
   parameter logic [31:0] IO_SIZE     = 32'h100,
   parameter int          TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [XLEN-1:0]   cpu_wdata,
   input  logic [3:0]        cpu_be,
   output logic [XLEN-1:0]   cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_err,
   output logic              mmio_req,
   output logic              mmio_we,
   output logic [ADDR_W-1:0] mmio_addr,
   output logic [XLEN-1:0]   mmio_wdata,
   input  logic [XLEN-1:0]   mmio_rdata,
   input  logic              mmio_ready
);

   localparam int c_CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [ADDR_W-1:0]    r_addr;
   logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic                 w_req_nxt, w_we_nxt, w_ready_nxt, w_err_nxt, w_latch;
   logic [XLEN-1:0]      w_wdata_nxt, w_rdata_nxt, w_merged;
   logic [ADDR_W-1:0]    w_off;
   logic                 w_in_win, w_aligned, w_full, w_partial_err, w_rmw, w_timeout;

   // Unsigned offset wraps for addresses below the base, so one compare covers both ends.
   assign w_off     = cpu_addr - IO_BASE[ADDR_W-1:0];
   assign w_in_win  = (w_off < IO_SIZE[ADDR_W-1:0]);
   assign w_full    = (cpu_be == 4'b1111);
   assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT_CYC - 1));
   assign mmio_addr = {r_addr[ADDR_W-1:2], 2'b00};

   always_comb begin
      w_aligned = 1'b0;
      case (cpu_be)
         4'b1111, 4'b0011, 4'b1100,
         4'b0001, 4'b0010, 4'b0100, 4'b1000: w_aligned = 1'b1;
         default:                            w_aligned = 1'b0;
      endcase
   end

`ifdef MMIO_BRIDGE_RMW_EN
   logic [XLEN-1:0] r_wdata;
   logic [3:0]      r_be;
   logic            r_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdata <= '0;
         r_be    <= '0;
         r_we    <= 1'b0;
      end else if (w_latch) begin
         r_wdata <= cpu_wdata;
         r_be    <= cpu_be;
         r_we    <= cpu_we;
      end
   end

   // Only loads and partial stores pass through RD, so a latched store marks RMW.
   assign w_rmw         = r_we;
   assign w_partial_err = 1'b0;

   for (genvar i = 0; i < 4; i++) begin : g_merge
      assign w_merged[8*i +: 8] = r_be[i] ? r_wdata[8*i +: 8] : mmio_rdata[8*i +: 8];
   end
`else
   assign w_rmw         = 1'b0;
   assign w_partial_err = cpu_we & ~w_full;
   assign w_merged      = '0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = mmio_req;
      w_we_nxt    = mmio_we;
      w_wdata_nxt = mmio_wdata;
      w_rdata_nxt = cpu_rdata;
      w_ready_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      case (r_state)
         IDLE: begin
            if (cpu_req) begin
               w_latch = 1'b1;
               if (!w_in_win || !w_aligned || w_partial_err) begin
                  w_state_nxt = RESP;
                  w_ready_nxt = 1'b1;
                  w_err_nxt   = 1'b1;
                  w_rdata_nxt = '0;
               end else if (!cpu_we || !w_full) begin
                  w_state_nxt = RD;
                  w_req_nxt   = 1'b1;
                  w_we_nxt    = 1'b0;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = WR;
                  w_req_nxt   = 1'b1;
                  w_we_nxt    = 1'b1;
                  w_wdata_nxt = cpu_wdata;
                  w_cnt_nxt   = '0;
               end
            end
         end
         RD: begin
            if (mmio_ready) begin
               w_req_nxt = 1'b0;
               if (w_rmw) begin
                  w_state_nxt = WR;
                  w_we_nxt    = 1'b1;
                  w_wdata_nxt = w_merged;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = RESP;
                  w_ready_nxt = 1'b1;
                  w_rdata_nxt = mmio_rdata;
               end
            end else if (w_timeout) begin
               w_state_nxt = RESP;
               w_req_nxt   = 1'b0;
               w_ready_nxt = 1'b1;
               w_err_nxt   = 1'b1;
               w_rdata_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         WR: begin
            // After the RMW read beat, mmio_req restarts here following one idle cycle.
            if (!mmio_req) begin
               w_req_nxt = 1'b1;
            end else if (mmio_ready || w_timeout) begin
               w_state_nxt = RESP;
               w_req_nxt   = 1'b0;
               w_we_nxt    = 1'b0;
               w_ready_nxt = 1'b1;
               w_err_nxt   = ~mmio_ready;
               w_rdata_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         RESP: begin
            w_state_nxt = IDLE;
            w_rdata_nxt = '0;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_cnt      <= '0;
         mmio_req   <= 1'b0;
         mmio_we    <= 1'b0;
         mmio_wdata <= '0;
         cpu_rdata  <= '0;
         cpu_ready  <= 1'b0;
         cpu_err    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         mmio_req   <= w_req_nxt;
         mmio_we    <= w_we_nxt;
         mmio_wdata <= w_wdata_nxt;
         cpu_rdata  <= w_rdata_nxt;
         cpu_ready  <= w_ready_nxt;
         cpu_err    <= w_err_nxt;
         if (w_latch) r_addr <= cpu_addr;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mmio_bridge.sv
// ============================================================================
// Module   : tb_mmio_bridge
// Brief    : Directed self-checking bench for mmio_bridge with a wait-state
//            programmable slave model.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef IO_LED_OFFSET
`define IO_LED_OFFSET 32'h0
`endif

module tb_mmio_bridge;

   localparam logic [31:0] c_BASE = 32'h4000_0000;
   localparam logic [31:0] c_SIZE = 32'h100;
   localparam int          c_TO   = 16;
   localparam logic [31:0] c_LED  = c_BASE + `IO_LED_OFFSET;

   logic        clk, rst_n;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [3:0]  cpu_be;
   logic        cpu_ready, cpu_err;
   logic        mmio_req, mmio_we, mmio_ready;
   logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;

   int checks   = 0;
   int failures = 0;

   mmio_bridge #(
      .ADDR_W(32), .XLEN(32), .IO_BASE(c_BASE), .IO_SIZE(c_SIZE), .TIMEOUT_CYC(c_TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
      .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
      .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Slave: ready once mmio_req has waited slave_wait cycles.
   int          slave_wait = 0;
   int          wcnt;
   logic [31:0] mem [4];

   assign mmio_ready = mmio_req && (wcnt >= slave_wait);
   assign mmio_rdata = mem[mmio_addr[3:2]];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt <= 0;
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else begin
         wcnt <= (mmio_req && !mmio_ready) ? wcnt + 1 : 0;
         if (mmio_req && mmio_ready && mmio_we) mem[mmio_addr[3:2]] <= mmio_wdata;
      end
   end

   int          req_cycles = 0, wr_beats = 0, ready_pulses = 0;
   logic [31:0] last_wdata = '0, last_addr = '0;

   always @(negedge clk) begin
      if (mmio_req) req_cycles <= req_cycles + 1;
      if (cpu_ready) ready_pulses <= ready_pulses + 1;
      if (mmio_req && mmio_ready) last_addr <= mmio_addr;
      if (mmio_req && mmio_ready && mmio_we) begin
         wr_beats   <= wr_beats + 1;
         last_wdata <= mmio_wdata;
      end
   end

   logic [31:0] rd;
   logic        er;
   int          lat, d_req, d_wr;

   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
      int  r0, w0;
      bit  got;
      @(negedge clk);
      r0 = req_cycles; w0 = wr_beats;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_be = be;
      got = 0; lat = -1; rd = 'x; er = 1'bx;
      for (int k = 1; k <= 200 && !got; k++) begin
         @(negedge clk);
         if (cpu_ready) begin
            got = 1; lat = k; rd = cpu_rdata; er = cpu_err;
         end
      end
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'b0;
      d_req = req_cycles - r0;
      d_wr  = wr_beats - w0;
      if (!got) begin
         checks++; failures++;
         $display("FAIL access_bound addr=%h no cpu_ready within 200 cycles", addr);
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({cpu_ready, cpu_err, mmio_req, mmio_we} !== 4'b0) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=0000", {cpu_ready, cpu_err, mmio_req, mmio_we});
      end
      checks++;
      if ((mmio_addr | mmio_wdata | cpu_rdata) !== 32'h0) begin
         failures++;
         $display("FAIL reset_data addr=%h wdata=%h rdata=%h exp=0", mmio_addr, mmio_wdata, cpu_rdata);
      end
   endtask

   task automatic test_store;
      access(1'b1, c_LED, 32'h0000_1234, 4'b1111);
      checks++;
      if ({er, lat} !== {1'b0, 32'd2}) begin
         failures++; $display("FAIL store_lat_err err=%b lat=%0d exp err=0 lat=2", er, lat);
      end
      checks++;
      if (d_wr !== 1 || last_wdata !== 32'h0000_1234 || last_addr !== c_LED) begin
         failures++;
         $display("FAIL store_beat beats=%0d wdata=%h addr=%h exp 1 00001234 %h", d_wr, last_wdata, last_addr, c_LED);
      end
      checks++;
      if (mem[0] !== 32'h0000_1234 || rd !== 32'h0) begin
         failures++; $display("FAIL store_led led=%h rdata=%h exp 00001234 0", mem[0], rd);
      end
   endtask

   task automatic test_load;
      access(1'b1, c_LED, 32'h0000_A5A5, 4'b1111);
      access(1'b0, c_LED, 32'h0, 4'b1111);
      checks++;
      if (rd !== 32'h0000_A5A5 || er !== 1'b0 || lat !== 2) begin
         failures++; $display("FAIL load_led rdata=%h err=%b lat=%0d exp 0000a5a5 0 2", rd, er, lat);
      end
      checks++;
      if (d_req !== 1 || d_wr !== 0) begin
         failures++; $display("FAIL load_traffic req=%0d wr=%0d exp 1 0", d_req, d_wr);
      end
      @(negedge clk);
      checks++;
      if (cpu_ready !== 1'b0) begin
         failures++; $display("FAIL ready_pulse got=%b exp=0", cpu_ready);
      end
      access(1'b1, c_BASE + 32'h4, 32'h1122_3344, 4'b1111);
      access(1'b0, c_BASE + 32'h6, 32'h0, 4'b0100);
      checks++;
      if (rd !== 32'h1122_3344 || last_addr !== c_BASE + 32'h4 || er !== 1'b0) begin
         failures++; $display("FAIL lane_load rdata=%h addr=%h err=%b exp 11223344 %h 0", rd, last_addr, er, c_BASE + 32'h4);
      end
   endtask

   task automatic test_partial_store;
`ifdef MMIO_BRIDGE_RMW_EN
      access(1'b1, c_LED, 32'h0000_003C, 4'b0001);
      checks++;
      if (er !== 1'b0 || lat !== 4 || d_req !== 2 || d_wr !== 1) begin
         failures++; $display("FAIL rmw_byte err=%b lat=%0d req=%0d wr=%0d exp 0 4 2 1", er, lat, d_req, d_wr);
      end
      checks++;
      if (last_wdata !== 32'h0000_A53C) begin
         failures++; $display("FAIL rmw_merge got=%h exp=0000a53c", last_wdata);
      end
      access(1'b0, c_LED, 32'h0, 4'b1111);
      checks++;
      if (rd !== 32'h0000_A53C) begin
         failures++; $display("FAIL rmw_readback got=%h exp=0000a53c", rd);
      end
      access(1'b1, c_BASE + 32'h6, 32'hBEEF_0000, 4'b1100);
      checks++;
      if (mem[1] !== 32'hBEEF_3344 || er !== 1'b0) begin
         failures++; $display("FAIL rmw_half got=%h err=%b exp beef3344 0", mem[1], er);
      end
`else
      access(1'b1, c_LED, 32'h0000_003C, 4'b0001);
      checks++;
      if (er !== 1'b1 || lat !== 1 || d_req !== 0) begin
         failures++; $display("FAIL partial_err err=%b lat=%0d req=%0d exp 1 1 0", er, lat, d_req);
      end
      checks++;
      if (mem[0] !== 32'h0000_A5A5) begin
         failures++; $display("FAIL partial_nowrite led=%h exp=0000a5a5", mem[0]);
      end
`endif
   endtask

   task automatic test_decode_err;
      logic [31:0] addrs [4];
      logic [3:0]  bes   [4];
      addrs[0] = c_BASE + c_SIZE; bes[0] = 4'b1111;
      addrs[1] = c_BASE + 32'h8;  bes[1] = 4'b0110;
      addrs[2] = c_BASE - 32'h4;  bes[2] = 4'b1111;
      addrs[3] = c_BASE + 32'hC;  bes[3] = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         access(i[0], addrs[i], 32'hDEAD_BEEF, bes[i]);
         checks++;
         if (er !== 1'b1 || lat !== 1 || d_req !== 0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL decode_err[%0d] err=%b lat=%0d req=%0d rdata=%h exp 1 1 0 0", i, er, lat, d_req, rd);
         end
      end
   endtask

   task automatic test_timeout;
      slave_wait = 1000;
      access(1'b0, c_LED, 32'h0, 4'b1111);
      checks++;
      if (er !== 1'b1 || lat !== c_TO + 1 || d_req !== c_TO || rd !== 32'h0) begin
         failures++; $display("FAIL rd_timeout err=%b lat=%0d req=%0d rdata=%h exp 1 %0d %0d 0", er, lat, d_req, rd, c_TO + 1, c_TO);
      end
      checks++;
      if (mmio_req !== 1'b0) begin
         failures++; $display("FAIL timeout_req_drop got=%b exp=0", mmio_req);
      end
      access(1'b1, c_BASE + 32'hC, 32'h7777_7777, 4'b1111);
      checks++;
      if (er !== 1'b1 || d_wr !== 0 || mem[3] !== 32'h0) begin
         failures++; $display("FAIL wr_timeout err=%b wr=%0d mem=%h exp 1 0 0", er, d_wr, mem[3]);
      end
      slave_wait = c_TO - 1;
      access(1'b0, c_LED, 32'h0, 4'b1111);
      checks++;
      if (er !== 1'b0 || lat !== c_TO + 1 || rd !== mem[0]) begin
         failures++; $display("FAIL ready_wins err=%b lat=%0d rdata=%h exp 0 %0d %h", er, lat, rd, c_TO + 1, mem[0]);
      end
      slave_wait = 0;
   endtask

   task automatic test_reset_mid_wr;
      int p0;
      slave_wait = 1000;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = c_BASE + 32'h8; cpu_wdata = 32'hCAFE_F00D; cpu_be = 4'b1111;
      repeat (3) @(negedge clk);
      checks++;
      if ({mmio_req, mmio_we} !== 2'b11) begin
         failures++; $display("FAIL mid_wr_active got=%b exp=11", {mmio_req, mmio_we});
      end
      p0 = ready_pulses;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({mmio_req, cpu_ready} !== 2'b00) begin
         failures++; $display("FAIL async_reset req/ready=%b exp=00", {mmio_req, cpu_ready});
      end
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 4'b0;
      slave_wait = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (ready_pulses !== p0 || mem[2] !== 32'h0) begin
         failures++; $display("FAIL reset_no_ready pulses=%0d mem=%h exp %0d 0", ready_pulses, mem[2], p0);
      end
      access(1'b1, c_LED, 32'h0000_5A5A, 4'b1111);
      access(1'b0, c_LED, 32'h0, 4'b1111);
      checks++;
      if (rd !== 32'h0000_5A5A || er !== 1'b0 || lat !== 2) begin
         failures++; $display("FAIL post_reset rdata=%h err=%b lat=%0d exp 00005a5a 0 2", rd, er, lat);
      end
   endtask

   initial begin
      rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
      repeat (3) @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      test_store;
      test_load;
      test_partial_store;
      test_decode_err;
      test_timeout;
      test_reset_mid_wr;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
